// File: rtl/seq_mult_param.sv
// Parametrised shift-add sequential multiplier with signed/unsigned mode and start/busy/done handshake.
// Optional overflow flag output enabled by defining SEQ_MULT_OVF_FLAG_EN.
module seq_mult_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 busy,
`ifdef SEQ_MULT_OVF_FLAG_EN
   output logic                 ovf,
`endif
   output logic                 done
);

   // Handshake: start is accepted on any edge where busy=0 (IDLE or DONE);
   // done is high for exactly the one cycle after Product is updated.
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [WIDTH-1:0]     mcand;
   logic                 mode;
   logic [WIDTH:0]       acc_hi;
   logic [WIDTH-1:0]     acc_lo;
   logic [CNT_W-1:0]     cnt;
   logic                 load;
   logic                 last_iter;
   logic                 last;
   logic [WIDTH:0]       mcand_ext;
   logic [WIDTH:0]       addend;
   logic [WIDTH+1:0]     sum;
   logic [WIDTH:0]       hi_shift;
   logic [WIDTH-1:0]     lo_shift;
   logic [2*WIDTH-1:0]   result;

   assign last_iter = (cnt == CNT_W'(WIDTH - 1));
   assign load      = start && (state != S_RUN);
   assign last      = (state == S_RUN) && last_iter;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last_iter) state_nxt = S_DONE;
         S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end

   // The top multiplier bit carries negative weight in two's complement, so the last
   // signed iteration subtracts the multiplicand instead of adding it.
   always_comb begin
      mcand_ext = mode ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
      addend    = (mode && last_iter) ? ((~mcand_ext) + {{WIDTH{1'b0}}, 1'b1}) : mcand_ext;
      sum       = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, addend}) : {1'b0, acc_hi};
      hi_shift  = {(mode ? sum[WIDTH] : sum[WIDTH+1]), sum[WIDTH:1]};
      lo_shift  = {sum[0], acc_lo[WIDTH-1:1]};
      result    = {hi_shift[WIDTH-1:0], lo_shift};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand   <= '0;
         mode    <= 1'b0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         cnt     <= '0;
         Product <= '0;
      end else if (load) begin
         mcand  <= A;
         mode   <= is_signed;
         acc_hi <= '0;
         acc_lo <= B;
         cnt    <= '0;
      end else if (state == S_RUN) begin
         acc_hi <= hi_shift;
         acc_lo <= lo_shift;
         cnt    <= cnt + CNT_W'(1);
         if (last) Product <= result;
      end
   end

`ifdef SEQ_MULT_OVF_FLAG_EN
   logic ovf_nxt;

   // Signed results fit only when the upper WIDTH+1 bits are a pure sign extension.
   always_comb begin
      if (mode) ovf_nxt = !((&result[2*WIDTH-1:WIDTH-1]) || !(|result[2*WIDTH-1:WIDTH-1]));
      else      ovf_nxt = |result[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       ovf <= 1'b0;
      else if (last) ovf <= ovf_nxt;
   end
`endif

endmodule
